// File: rtl/spmm_bsr_seq.sv
// Block-sparse (BSR) AV-multiply sequencer: walks row_ptr/col_idx and streams one
// (row, col, dim) beat per non-zero block per head dimension, with a wrapping checksum.
module spmm_bsr_seq #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned IDX_W  = 16,
  parameter int unsigned CSUM_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_m_blocks,
  input  logic [CNT_W-1:0]  cfg_d,
  output logic              rp_rd_en,
  output logic [CNT_W:0]    rp_addr,
  input  logic [IDX_W-1:0]  rp_data,
  output logic              ci_rd_en,
  output logic [IDX_W-1:0]  ci_addr,
  input  logic [IDX_W-1:0]  ci_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic [CNT_W-1:0]  out_d,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum_out,
  output logic              err_sticky
);

  typedef enum logic [2:0] {
    StIdle, StRp0, StRp1, StRpw, StCi, StCiw, StEmit, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   r_q, r_d, d_q, d_d;
  logic [IDX_W-1:0]   k_q, k_d, beg_q, beg_d, end_q, end_d, col_q, col_d;
  logic [CSUM_W-1:0]  csum_q, csum_d, csum_out_q, csum_out_d;
  logic               err_q, err_d;

  // Increments and limits compared one bit wider so all-ones configs do not wrap.
  logic [CNT_W:0]     r_inc, d_inc;
  logic [IDX_W:0]     k_inc;
  logic               row_more, dim_more, blk_more;
  logic [CSUM_W-1:0]  beat_sum;

  assign r_inc    = {1'b0, r_q} + (CNT_W+1)'(1);
  assign d_inc    = {1'b0, d_q} + (CNT_W+1)'(1);
  assign k_inc    = {1'b0, k_q} + (IDX_W+1)'(1);
  assign row_more = r_inc < {1'b0, cfg_m_blocks};
  assign dim_more = d_inc < {1'b0, cfg_d};
  assign blk_more = k_inc < {1'b0, end_q};
  assign beat_sum = CSUM_W'(r_q) + CSUM_W'(col_q) + CSUM_W'(d_q);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    d_d        = d_q;
    k_d        = k_q;
    beg_d      = beg_q;
    end_d      = end_q;
    col_d      = col_q;
    csum_d     = csum_q;
    csum_out_d = csum_out_q;
    err_d      = err_q;
    rp_rd_en   = 1'b0;
    rp_addr    = '0;
    ci_rd_en   = 1'b0;
    ci_addr    = '0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          r_d    = '0;
          k_d    = '0;
          d_d    = '0;
          csum_d = '0;
          err_d  = 1'b0;
          state_d = (cfg_m_blocks == '0 || cfg_d == '0) ? StDone : StRp0;
        end
      end
      StRp0: begin
        busy     = 1'b1;
        rp_rd_en = 1'b1;
        rp_addr  = {1'b0, r_q};
        state_d  = StRp1;
      end
      StRp1: begin
        busy     = 1'b1;
        beg_d    = rp_data;
        rp_rd_en = 1'b1;
        rp_addr  = r_inc;
        state_d  = StRpw;
      end
      StRpw: begin
        busy  = 1'b1;
        end_d = rp_data;
        k_d   = beg_q;
        if (rp_data > beg_q) begin
          state_d = StCi;
        end else begin
          // Malformed rows are flagged but otherwise skipped like empty ones.
          if (rp_data < beg_q) err_d = 1'b1;
          if (row_more) begin
            r_d     = r_inc[CNT_W-1:0];
            state_d = StRp0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StCi: begin
        busy     = 1'b1;
        ci_rd_en = 1'b1;
        ci_addr  = k_q;
        state_d  = StCiw;
      end
      StCiw: begin
        busy    = 1'b1;
        col_d   = ci_data;
        d_d     = '0;
        state_d = StEmit;
      end
      StEmit: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          csum_d = csum_q + beat_sum;
          if (dim_more) begin
            d_d = d_inc[CNT_W-1:0];
          end else if (blk_more) begin
            k_d     = k_inc[IDX_W-1:0];
            state_d = StCi;
          end else if (row_more) begin
            r_d     = r_inc[CNT_W-1:0];
            state_d = StRp0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done       = 1'b1;
        csum_out_d = csum_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over start and over any beat handshake this cycle.
    if (abort && state_q != StIdle) begin
      state_d    = StIdle;
      csum_d     = csum_q;
      csum_out_d = csum_out_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      r_q        <= '0;
      d_q        <= '0;
      k_q        <= '0;
      beg_q      <= '0;
      end_q      <= '0;
      col_q      <= '0;
      csum_q     <= '0;
      csum_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      d_q        <= d_d;
      k_q        <= k_d;
      beg_q      <= beg_d;
      end_q      <= end_d;
      col_q      <= col_d;
      csum_q     <= csum_d;
      csum_out_q <= csum_out_d;
      err_q      <= err_d;
    end
  end

  assign out_row      = r_q;
  assign out_col      = col_q;
  assign out_d        = d_q;
  assign checksum_out = csum_out_q;
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_spmm_bsr_seq.sv
// Scoreboard bench for spmm_bsr_seq: a nested-loop BSR model fills an expected-beat queue,
// a negedge monitor pops and compares on each accepted beat.
module tb_spmm_bsr_seq;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned CSUM_W = 64;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  cfg_m_blocks = '0;
  logic [CNT_W-1:0]  cfg_d = '0;
  logic              rp_rd_en;
  logic [CNT_W:0]    rp_addr;
  logic [IDX_W-1:0]  rp_data = '0;
  logic              ci_rd_en;
  logic [IDX_W-1:0]  ci_addr;
  logic [IDX_W-1:0]  ci_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_col;
  logic [CNT_W-1:0]  out_d;
  logic              busy;
  logic              done;
  logic [CSUM_W-1:0] checksum_out;
  logic              err_sticky;

  spmm_bsr_seq #(.CNT_W(CNT_W), .IDX_W(IDX_W), .CSUM_W(CSUM_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_m_blocks(cfg_m_blocks), .cfg_d(cfg_d),
    .rp_rd_en(rp_rd_en), .rp_addr(rp_addr), .rp_data(rp_data),
    .ci_rd_en(ci_rd_en), .ci_addr(ci_addr), .ci_data(ci_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_d(out_d),
    .busy(busy), .done(done), .checksum_out(checksum_out), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] d;
  } beat_t;

  beat_t        exp_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           beats_seen = 0;
  bit           rand_rdy = 1'b0;
  logic [15:0]  rp_mem[64];
  logic [15:0]  ci_mem[64];
  logic [63:0]  last_csum = '0;

  // Memories with 1-cycle read latency.
  always @(posedge clk) begin
    if (rp_rd_en) rp_data <= rp_mem[int'(rp_addr) % 64];
    if (ci_rd_en) ci_data <= ci_mem[int'(ci_addr) % 64];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every accepted beat and checks hold-while-stalled.
  bit          stall = 1'b0;
  logic [47:0] held = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      stall = 1'b0;
    end else begin
      if (stall) check("stall_hold", {15'd0, out_valid, out_row, out_col, out_d}, {15'd0, 1'b1, held});
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_row, out_col, out_d});
        end else begin
          check("beat", {16'd0, out_row, out_col, out_d}, {16'd0, exp_q.pop_front()});
          beats_seen++;
        end
      end
      stall = out_valid && !out_ready && !abort;
      held  = {out_row, out_col, out_d};
    end
  end

  // Reference: plain nested loops over the BSR structure.
  task automatic build_model(input int m, input int dd, output logic [63:0] sum,
                             output bit err, output int cyc);
    sum = '0;
    err = 1'b0;
    cyc = 1;
    if (m == 0 || dd == 0) return;
    for (int r = 0; r < m; r++) begin
      int b = int'(rp_mem[r]);
      int e = int'(rp_mem[r+1]);
      cyc += 3;
      if (e < b) err = 1'b1;
      for (int k = b; k < e; k++) begin
        cyc += 2 + dd;
        for (int j = 0; j < dd; j++) begin
          exp_q.push_back('{row: 16'(r), col: ci_mem[k], d: 16'(j)});
          sum += 64'(r) + 64'(ci_mem[k]) + 64'(j);
        end
      end
    end
  endtask

  task automatic kick(input int m, input int dd);
    @(posedge clk);
    #1;
    cfg_m_blocks = 16'(m);
    cfg_d        = 16'(dd);
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_case(input int m, input int dd, input bit rnd, input bit poke);
    logic [63:0] esum;
    bit          eerr;
    int          ecyc, cyc, busy_cnt;
    build_model(m, dd, esum, eerr, ecyc);
    rand_rdy = rnd;
    kick(m, dd);
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 4000) begin
      if (busy) busy_cnt++;
      start = poke && (cyc == 4);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    if (!rnd) begin
      check("done_cycle", 64'(cyc), 64'(ecyc));
      check("busy_cycles", 64'(busy_cnt), 64'(ecyc - 1));
    end
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    check("checksum", checksum_out, esum);
    check("err_sticky", 64'(err_sticky), 64'(eerr));
    check("beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    last_csum = esum;
    rand_rdy = 1'b0;
  endtask

  task automatic load_nominal();
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd2; rp_mem[2] = 16'd3;
    ci_mem[0] = 16'd1; ci_mem[1] = 16'd3; ci_mem[2] = 16'd0;
  endtask

  initial begin
    logic [63:0] esum;
    bit          eerr;
    int          ecyc, w;
    for (int i = 0; i < 64; i++) begin
      rp_mem[i] = '0;
      ci_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {58'd0, busy, done, out_valid, rp_rd_en, ci_rd_en, err_sticky}, 64'd0);
    check("rst_csum", checksum_out, 64'd0);
    check("rst_data", {rp_addr, ci_addr, out_row, out_col}, 64'd0);
    rstn = 1'b1;

    // Nominal, with a start pulse mid-run that must be ignored.
    load_nominal();
    run_case(2, 2, 1'b0, 1'b1);
    check("nominal_13", last_csum, 64'd13);
    run_case(2, 2, 1'b1, 1'b0);

    // Empty and malformed rows.
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd0; rp_mem[2] = 16'd2; rp_mem[3] = 16'd1;
    ci_mem[0] = 16'd4; ci_mem[1] = 16'd5;
    run_case(3, 1, 1'b0, 1'b0);
    check("malformed_11", last_csum, 64'd11);

    // Abort on the third beat.
    load_nominal();
    esum = last_csum;
    build_model(2, 2, last_csum, eerr, ecyc);
    last_csum = esum;
    beats_seen = 0;
    kick(2, 2);
    w = 0;
    while (!(out_valid && beats_seen == 2) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("abort_reach", 64'(out_valid && beats_seen == 2), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_idle", {61'd0, out_valid, busy, done}, 64'd0);
    check("abort_csum", checksum_out, last_csum);
    check("abort_beats", 64'(beats_seen), 64'd2);
    exp_q.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_quiet", {62'd0, busy, done}, 64'd0);
    end
    run_case(2, 2, 1'b0, 1'b0);
    check("post_abort_13", last_csum, 64'd13);

    // Zero configurations.
    run_case(0, 2, 1'b0, 1'b0);
    run_case(2, 0, 1'b0, 1'b0);

    // Random structures.
    for (int t = 0; t < 12; t++) begin
      int m = int'($urandom_range(1, 5));
      int dd = int'($urandom_range(1, 3));
      rp_mem[0] = 16'($urandom_range(0, 3));
      for (int i = 1; i <= m; i++) begin
        if ($urandom_range(0, 9) == 0) rp_mem[i] = 16'($urandom_range(0, int'(rp_mem[i-1])));
        else rp_mem[i] = rp_mem[i-1] + 16'($urandom_range(0, 3));
      end
      for (int i = 0; i < 64; i++) ci_mem[i] = 16'($urandom);
      run_case(m, dd, t[0], 1'b0);
    end

    // Reset in the middle of EMIT.
    load_nominal();
    build_model(2, 2, esum, eerr, ecyc);
    kick(2, 2);
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("rst_reach", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_async", {62'd0, out_valid, busy}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_mid_csum", checksum_out, 64'd0);
    check("rst_mid_err", 64'(err_sticky), 64'd0);
    run_case(2, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spmm_bsr_seq.md
# spmm_bsr_seq

Parametrised block-sparse (BSR) AV-multiply sequencer. It walks a BSR row-pointer / column-index structure through two read ports and emits one (block-row, block-col, dim) work beat per non-zero block per head dimension on a valid/ready stream. It accumulates a wrapping checksum over accepted beats. It sits between the attention controller (start/config) and the AV datapath (beat consumer).

## Interface
Parameters:
- CNT_W, 16, width of block-row count, dim count and row/dim outputs
- IDX_W, 16, width of row_ptr entries, col_idx addresses and column indices
- CSUM_W, 64, checksum width (≥ CNT_W+1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  begin traversal; sampled only in IDLE
- abort  in  1  cancel; return to IDLE next cycle
- cfg_m_blocks  in  CNT_W  number of block rows
- cfg_d  in  CNT_W  head dimension (beats per non-zero block)
- rp_rd_en  out  1  row_ptr read strobe
- rp_addr  out  CNT_W+1  row_ptr address
- rp_data  in  IDX_W  row_ptr data, valid the cycle after rp_rd_en
- ci_rd_en  out  1  col_idx read strobe
- ci_addr  out  IDX_W  col_idx address
- ci_data  in  IDX_W  col_idx data, valid the cycle after ci_rd_en
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_row  out  CNT_W  block row
- out_col  out  IDX_W  block column
- out_d  out  CNT_W  dim index
- busy  out  1  traversal in progress
- done  out  1  one-cycle completion pulse
- checksum_out  out  CSUM_W  final checksum, held until the next start
- err_sticky  out  1  malformed row_ptr seen; cleared on start

## Operation
- States: IDLE, RP0, RP1, RPW, CI, CIW, EMIT, DONE.
- IDLE:
  - With start=1 and either config field zero, go to DONE (zero work; checksum_out=0).
  - With start=1 otherwise, clear r, k, d, checksum and err_sticky, then go to RP0.
- RP0: rp_rd_en=1, rp_addr=r; go to RP1.
- RP1: capture beg=rp_data; rp_rd_en=1, rp_addr=r+1; go to RPW.
- RPW: capture end=rp_data; set k=beg.
  - If end>beg, go to CI.
  - If end<beg, set err_sticky and treat the row as empty.
  - For an empty row: if r+1<cfg_m_blocks, r++ and go to RP0; else go to DONE.
- CI: ci_rd_en=1, ci_addr=k; go to CIW.
- CIW: capture col=ci_data; d=0; go to EMIT.
- EMIT: out_valid=1 with (r, col, d). On each handshake (out_valid & out_ready):
  - Add zero-extended out_row+out_col+out_d to checksum, mod 2^CSUM_W.
  - If d+1<cfg_d, d++.
  - Else if k+1<end, k++ and go to CI.
  - Else if r+1<cfg_m_blocks, r++ and go to RP0.
  - Else go to DONE.
- DONE: done=1; checksum_out <= final checksum (including the last beat); go to IDLE.
- busy=1 in RP0..EMIT; busy=0 in IDLE and DONE.
- Comparisons are done at CNT_W+1 / IDX_W+1 width, so all-ones config values do not wrap.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, out_valid, rp_rd_en, ci_rd_en, err_sticky = 0.
  - All address, data and checksum outputs = 0.
- Read ports have fixed 1-cycle latency; no backpressure on them.
- start is ignored while not in IDLE (including DONE).
- With out_ready=1:
  - Each row costs 3 cycles.
  - Each non-zero block costs 2 + cfg_d cycles.
  - DONE costs 1 cycle.
- out_row, out_col and out_d are stable while out_valid & !out_ready; out_valid never drops without a handshake except on abort.
- abort (any state except IDLE): next cycle state=IDLE, out_valid=0, busy=0, no done pulse, checksum_out unchanged. abort has priority over start and over a handshake in the same cycle; a beat presented in that cycle is not counted.
- Reset mid-operation: immediate return to reset values.

## Test plan
- Nominal: m=2, d=2, row_ptr={0,2,3}, col_idx={1,3,0}, out_ready=1, start pulsed in cycle 0.
  - Beats: (0,1,0) (0,1,1) (0,3,0) (0,3,1) (1,0,0) (1,0,1).
  - busy high in cycles 1–18, done in cycle 19, checksum_out=13.
- Backpressure: same data, out_ready random 50%.
  - Identical beat sequence and checksum=13.
  - Outputs stable while stalled.
- Empty and malformed rows: m=3, d=1, row_ptr={0,0,2,1}, col_idx={4,5}.
  - Beats: (1,4,0) (1,5,0).
  - checksum=11, err_sticky=1.
- Zero config: start with m=0, or with d=0.
  - done the cycle after start, no beats, checksum_out=0.
- Abort: nominal run with abort asserted on the 3rd beat with out_ready=1.
  - IDLE next cycle, no done, checksum_out keeps its prior value.
  - A following start runs to checksum=13.
- Start ignored plus reset: start pulsed while busy has no effect. rstn low mid-EMIT gives out_valid=0 and busy=0 immediately.
